wb_scoreboard: RTL and testbench

Writeback stage of the pipelined core, the producer end of the decode stage's register-file write port. Registers the memory-stage result (MEM/WB latch), selects the writeback value, and drives `wbdata`, `RegWrt_out`, `RegDst_addr` into decode's bypassing register file. Also keeps a per-register scoreboard of in-flight writes and raises `stall` when the instruction in decode reads a register whose write has not yet committed.

---
 rtl/wb_scoreboard.sv | 120 ++++++++++++
 tb/tb_wb_scoreboard.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// Writeback stage: MEM/WB latch, writeback source select, and a per-register
// scoreboard of in-flight writes that stalls decode on unresolved RAW hazards.
module wb_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_RegWrt,
    input  logic [2:0]  mem_RegDst_addr,
    input  logic [1:0]  mem_RegSrc,
    input  logic [15:0] mem_alu,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] mem_pc2,
    input  logic [15:0] mem_imm,
    input  logic        iss_valid,
    input  logic        iss_RegWrt,
    input  logic [2:0]  iss_dst,
    input  logic [2:0]  iss_src1,
    input  logic [2:0]  iss_src2,
    input  logic        iss_use1,
    input  logic        iss_use2,
    output logic [15:0] wbdata,
    output logic        RegWrt_out,
    output logic [2:0]  RegDst_addr,
    output logic        stall,
    output logic        err
);

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 3;
    localparam int unsigned NREG = 8;
    localparam int unsigned CW   = 2;

    localparam logic [CW-1:0] PEND_MAX = CW'(3);

    logic                     wb_valid_q;
    logic                     wb_regwrt_q;
    logic [AW-1:0]            wb_addr_q;
    logic [DW-1:0]            wb_q;
    logic [DW-1:0]            wb_sel;
    logic [NREG-1:0][CW-1:0]  pend;
    logic [NREG-1:0][CW-1:0]  pend_nxt;
    logic                     err_q;
    logic                     err_nxt;
    logic                     blk1;
    logic                     blk2;
    logic                     issue_acc;
    logic                     inc_hit;
    logic                     dec_hit;

    // Writeback value mux: ALU, memory, PC+2, immediate
    always_comb begin
        wb_sel = mem_alu;
        case (mem_RegSrc)
            2'b00:   wb_sel = mem_alu;
            2'b01:   wb_sel = mem_rdata;
            2'b10:   wb_sel = mem_pc2;
            default: wb_sel = mem_imm;
        endcase
    end

    // MEM/WB latch; the stage never stalls so there is no enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q  <= 1'b0;
            wb_regwrt_q <= 1'b0;
            wb_addr_q   <= '0;
            wb_q        <= '0;
        end else begin
            wb_valid_q  <= mem_valid;
            wb_regwrt_q <= mem_RegWrt;
            wb_addr_q   <= mem_RegDst_addr;
            wb_q        <= wb_sel;
        end
    end

    assign wbdata      = wb_q;
    assign RegWrt_out  = wb_valid_q & wb_regwrt_q;
    assign RegDst_addr = wb_addr_q;
    assign err         = err_q;

    // A source whose last pending write commits this cycle arrives via bypass
    always_comb begin
        blk1 = iss_use1 && (pend[iss_src1] != '0) &&
               !((pend[iss_src1] == CW'(1)) && RegWrt_out && (RegDst_addr == iss_src1));
        blk2 = iss_use2 && (pend[iss_src2] != '0) &&
               !((pend[iss_src2] == CW'(1)) && RegWrt_out && (RegDst_addr == iss_src2));
        stall     = iss_valid && (blk1 || blk2);
        issue_acc = iss_valid && iss_RegWrt && !stall;
    end

    // Counter update with saturation at 3 and floor at 0, both flagging err
    always_comb begin
        pend_nxt = pend;
        err_nxt  = err_q;
        inc_hit  = 1'b0;
        dec_hit  = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            inc_hit = issue_acc && (iss_dst == AW'(r));
            dec_hit = RegWrt_out && (RegDst_addr == AW'(r));
            if (inc_hit && !dec_hit) begin
                if (pend[r] == PEND_MAX) err_nxt = 1'b1;
                else                     pend_nxt[r] = pend[r] + CW'(1);
            end else if (dec_hit && !inc_hit) begin
                if (pend[r] == '0) err_nxt = 1'b1;
                else               pend_nxt[r] = pend[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend  <= '0;
            err_q <= 1'b0;
        end else begin
            pend  <= pend_nxt;
            err_q <= err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Randomized and directed checks of wb_scoreboard against a cycle-level
// behavioural model of the writeback latch and in-flight write counts.
module tb_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_RegWrt;
    logic [2:0]  mem_RegDst_addr;
    logic [1:0]  mem_RegSrc;
    logic [15:0] mem_alu, mem_rdata, mem_pc2, mem_imm;
    logic        iss_valid, iss_RegWrt;
    logic [2:0]  iss_dst, iss_src1, iss_src2;
    logic        iss_use1, iss_use2;
    logic [15:0] wbdata;
    logic        RegWrt_out;
    logic [2:0]  RegDst_addr;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Model: outstanding write count per register, plus what the WB stage holds
    int          m_pend [8];
    bit          m_err;
    bit          m_we;
    int          m_addr;
    logic [15:0] m_data;
    bit          m_stall;

    wb_scoreboard dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_RegWrt(mem_RegWrt),
        .mem_RegDst_addr(mem_RegDst_addr), .mem_RegSrc(mem_RegSrc),
        .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_pc2(mem_pc2), .mem_imm(mem_imm),
        .iss_valid(iss_valid), .iss_RegWrt(iss_RegWrt), .iss_dst(iss_dst),
        .iss_src1(iss_src1), .iss_src2(iss_src2),
        .iss_use1(iss_use1), .iss_use2(iss_use2),
        .wbdata(wbdata), .RegWrt_out(RegWrt_out), .RegDst_addr(RegDst_addr),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit src_blocked(input bit use_s, input int src);
        if (!use_s || m_pend[src] == 0) return 1'b0;
        // last outstanding write for this register is being written right now
        if (m_pend[src] == 1 && m_we && m_addr == src) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        foreach (m_pend[r]) m_pend[r] = 0;
        m_err  = 1'b0;
        m_we   = 1'b0;
        m_addr = 0;
        m_data = 16'h0;
    endtask

    task automatic set_idle();
        mem_valid = 0; mem_RegWrt = 0; mem_RegDst_addr = 0; mem_RegSrc = 0;
        mem_alu = 0; mem_rdata = 0; mem_pc2 = 0; mem_imm = 0;
        iss_valid = 0; iss_RegWrt = 0; iss_dst = 0; iss_src1 = 0; iss_src2 = 0;
        iss_use1 = 0; iss_use2 = 0;
    endtask

    task automatic set_random(input int addr_span);
        mem_valid = 1'($urandom); mem_RegWrt = 1'($urandom);
        mem_RegDst_addr = 3'($urandom_range(addr_span - 1));
        mem_RegSrc = 2'($urandom);
        mem_alu = 16'($urandom); mem_rdata = 16'($urandom);
        mem_pc2 = 16'($urandom); mem_imm = 16'($urandom);
        iss_valid = 1'($urandom); iss_RegWrt = 1'($urandom);
        iss_dst  = 3'($urandom_range(addr_span - 1));
        iss_src1 = 3'($urandom_range(addr_span - 1));
        iss_src2 = 3'($urandom_range(addr_span - 1));
        iss_use1 = 1'($urandom); iss_use2 = 1'($urandom);
    endtask

    task automatic mem_write(input int dst, input logic [1:0] sel);
        mem_valid = 1; mem_RegWrt = 1; mem_RegDst_addr = 3'(dst); mem_RegSrc = sel;
    endtask

    task automatic issue(input bit wr, input int dst, input bit u1, input int s1,
                         input bit u2, input int s2);
        iss_valid = 1; iss_RegWrt = wr; iss_dst = 3'(dst);
        iss_use1 = u1; iss_src1 = 3'(s1); iss_use2 = u2; iss_src2 = 3'(s2);
    endtask

    // Called at a falling edge with inputs applied; checks, then advances one cycle
    task automatic cycle();
        logic [15:0] cand [4];
        int          delta;
        bit          acc;
        #1;
        m_stall = iss_valid && (src_blocked(iss_use1, int'(iss_src1)) ||
                                src_blocked(iss_use2, int'(iss_src2)));
        check_val("wbdata",      wbdata,            m_data);
        check_val("RegWrt_out",  16'(RegWrt_out),   16'(m_we));
        check_val("RegDst_addr", 16'(RegDst_addr),  16'(m_addr));
        check_val("err",         16'(err),          16'(m_err));
        check_val("stall",       16'(stall),        16'(m_stall));
        @(posedge clk);
        acc = iss_valid && iss_RegWrt && !m_stall;
        for (int r = 0; r < 8; r++) begin
            delta = ((acc && int'(iss_dst) == r) ? 1 : 0) - ((m_we && m_addr == r) ? 1 : 0);
            if (delta > 0) begin
                if (m_pend[r] == 3) m_err = 1'b1; else m_pend[r]++;
            end else if (delta < 0) begin
                if (m_pend[r] == 0) m_err = 1'b1; else m_pend[r]--;
            end
        end
        cand[0] = mem_alu; cand[1] = mem_rdata; cand[2] = mem_pc2; cand[3] = mem_imm;
        m_we   = mem_valid && mem_RegWrt;
        m_addr = int'(mem_RegDst_addr);
        m_data = cand[int'(mem_RegSrc)];
        @(negedge clk);
    endtask

    // Async pulse between edges; outputs must clear without a clock edge
    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        check_val("rst_wbdata", wbdata,            16'h0);
        check_val("rst_regwrt", 16'(RegWrt_out),   16'h0);
        check_val("rst_addr",   16'(RegDst_addr),  16'h0);
        check_val("rst_stall",  16'(stall),        16'h0);
        check_val("rst_err",    16'(err),          16'h0);
        rst = 1'b1;
        model_clear();
        set_idle();
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        model_clear();
        rst = 1'b0;
        // Reset held with random inputs: everything stays zero
        repeat (4) begin
            @(negedge clk);
            set_random(8);
            #1;
            check_val("hold_wbdata", wbdata,           16'h0);
            check_val("hold_regwrt", 16'(RegWrt_out),  16'h0);
            check_val("hold_addr",   16'(RegDst_addr), 16'h0);
            check_val("hold_stall",  16'(stall),       16'h0);
            check_val("hold_err",    16'(err),         16'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        set_idle();

        // ALU write, then the three other sources, then an invalid slot
        mem_write(3, 2'b00); mem_alu = 16'h1234;
        cycle();
        set_idle();
        check_val("alu_data", wbdata, 16'h1234);
        check_val("alu_we",   16'(RegWrt_out),  16'h1);
        check_val("alu_addr", 16'(RegDst_addr), 16'h3);
        mem_rdata = 16'hBEEF; mem_pc2 = 16'h0042; mem_imm = 16'hFFF0; mem_alu = 16'h1111;
        mem_write(0, 2'b01); cycle(); check_val("sel_mem", wbdata, 16'hBEEF);
        mem_write(0, 2'b10); cycle(); check_val("sel_pc2", wbdata, 16'h0042);
        mem_write(0, 2'b11); cycle(); check_val("sel_imm", wbdata, 16'hFFF0);
        mem_valid = 0; cycle(); check_val("invalid_we", 16'(RegWrt_out), 16'h0);
        set_idle(); cycle();
        pulse_reset();

        // RAW hazard on r2 resolved by the commit-cycle bypass
        issue(1, 2, 0, 0, 0, 0); cycle();
        issue(0, 0, 1, 2, 0, 0); mem_write(2, 2'b00); mem_alu = 16'h0202;
        #1 check_val("raw_stall", 16'(stall), 16'h1);
        cycle();
        mem_valid = 0; mem_RegWrt = 0;
        #1 check_val("raw_bypass", 16'(stall), 16'h0);
        cycle();
        #1 check_val("raw_after", 16'(stall), 16'h0);
        check_val("raw_err", 16'(err), 16'h0);
        set_idle(); cycle();

        // Same-edge increment and decrement on r5
        issue(1, 5, 0, 0, 0, 0); cycle();
        set_idle(); mem_write(5, 2'b00); cycle();
        set_idle(); issue(1, 5, 0, 0, 0, 5); cycle();
        issue(0, 0, 0, 0, 0, 5);
        #1 check_val("r5_unused", 16'(stall), 16'h0);
        iss_use2 = 1;
        #1 check_val("r5_still_pend", 16'(stall), 16'h1);
        check_val("r5_err", 16'(err), 16'h0);
        cycle();
        pulse_reset();

        // Overflow: four writes to r1 with no commit
        repeat (3) begin issue(1, 1, 0, 0, 0, 0); cycle(); end
        check_val("ovf_err_before", 16'(err), 16'h0);
        issue(1, 1, 0, 0, 0, 0); cycle();
        set_idle();
        check_val("ovf_err", 16'(err), 16'h1);
        issue(0, 0, 1, 1, 0, 0);
        #1 check_val("ovf_stall", 16'(stall), 16'h1);
        cycle();
        pulse_reset();

        // Underflow: commit to r4 with nothing outstanding
        mem_write(4, 2'b00); cycle();
        set_idle(); cycle();
        check_val("unf_err", 16'(err), 16'h1);
        issue(0, 0, 1, 4, 1, 4);
        #1 check_val("unf_no_stall", 16'(stall), 16'h0);
        cycle();
        pulse_reset();

        // Async reset with r6 twice outstanding and a commit in the WB stage
        issue(1, 6, 0, 0, 0, 0); cycle();
        issue(1, 6, 0, 0, 0, 0); mem_write(0, 2'b00); cycle();
        issue(0, 0, 1, 6, 0, 0); mem_write(0, 2'b00);
        #1 check_val("mid_stall", 16'(stall), 16'h1);
        check_val("mid_we", 16'(RegWrt_out), 16'h1);
        pulse_reset();
        issue(0, 0, 1, 6, 1, 6);
        #1 check_val("post_rst_stall", 16'(stall), 16'h0);
        cycle();

        // Random traffic on a narrow register range, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            set_random((n % 2 == 0) ? 4 : 8);
            if ($urandom_range(3) != 0) mem_RegWrt = 1'b0;
            cycle();
            if ($urandom_range(199) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
